ptw_dbus_arb: RTL and testbench

- Sits directly downstream of the Sv32 MMU's page-table-walker port, between the MMU's PTW signals and the data-memory bus shared with the core's load/store port.
- Turns each held `ptw_req`/`ptw_addr` into one bus read and returns the PTE as a single-cycle `ptw_rvalid` pulse.
- Arbitrates the bus against the core D-port, with PTW having fixed priority.
- Enforces a PTE physical window and alignment, and bounds every bus wait with a timeout that reports `ptw_fault` or `core_err`.

---
 rtl/harvos_mem_pkg.sv | 17 +
 rtl/ptw_dbus_arb.sv | 158 +++++++++++++++
 tb/tb_ptw_dbus_arb.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/harvos_mem_pkg.sv
// Shared memory-system constants for the harvos core.
// PT window, bus timeout and the PTW/D-port arbiter state encoding.
package harvos_mem_pkg;

    localparam logic [31:0] PT_BASE_DEF = 32'h0010_0000;
    localparam logic [31:0] PT_END_DEF  = 32'h001F_FFFF;
    localparam logic [7:0]  TIMEOUT_DEF = 8'd255;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE      = 3'd0;
    localparam arb_state_t ST_PTW_WAIT  = 3'd1;
    localparam arb_state_t ST_CORE_WAIT = 3'd2;
    localparam arb_state_t ST_PTW_RESP  = 3'd3;
    localparam arb_state_t ST_DRAIN     = 3'd4;

endpackage

// File: rtl/ptw_dbus_arb.sv
// Shares the data bus between the Sv32 page-table walker and the core
// D-port; PTW has fixed priority, every bus wait is bounded by a timeout.
module ptw_dbus_arb
    import harvos_mem_pkg::*;
#(
    parameter logic [31:0] PT_BASE = PT_BASE_DEF,
    parameter logic [31:0] PT_END  = PT_END_DEF,
    parameter logic [7:0]  TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ptw_req,
    input  logic [31:0] ptw_addr,
    output logic [31:0] ptw_rdata,
    output logic        ptw_rvalid,
    output logic        ptw_fault,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic        core_we,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_be,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    function automatic logic in_window(input logic [31:0] a);
        return (a >= PT_BASE) && (a <= PT_END);
    endfunction

    arb_state_t state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       drain_pend;
    logic       ptw_ok;
    logic       ptw_bad;
    logic       in_idle;
    logic       in_cwait;
    logic       timeout;

    assign ptw_ok   = ptw_req && (ptw_addr[1:0] == 2'b00)
                      && in_window(ptw_addr);
    assign ptw_bad  = ptw_req && !ptw_ok;
    // Combinational bus/core outputs are forced quiet while in reset
    assign in_idle  = (state == ST_IDLE) && !rst;
    assign in_cwait = (state == ST_CORE_WAIT) && !rst;
    assign timeout  = (cnt == TIMEOUT);
    assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_comb begin
        bus_req     = 1'b0;
        bus_addr    = '0;
        bus_we      = 1'b0;
        bus_wdata   = '0;
        bus_be      = '0;
        core_gnt    = 1'b0;
        core_rvalid = 1'b0;
        core_rdata  = '0;
        core_err    = 1'b0;
        if (in_idle && ptw_ok) begin
            bus_req  = 1'b1;
            bus_addr = ptw_addr;
            bus_be   = 4'hF;
        end else if (in_idle && !ptw_req && core_req) begin
            bus_req   = 1'b1;
            bus_addr  = core_addr;
            bus_we    = core_we;
            bus_wdata = core_wdata;
            bus_be    = core_be;
            core_gnt  = bus_gnt;
        end
        if (in_cwait) begin
            core_rvalid = bus_rvalid || timeout;
            core_rdata  = bus_rdata;
            core_err    = bus_rvalid ? bus_err : timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            drain_pend <= 1'b0;
            ptw_rvalid <= 1'b0;
            ptw_fault  <= 1'b0;
            ptw_rdata  <= '0;
        end else begin
            ptw_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ptw_bad) begin
                        ptw_rdata  <= '0;
                        ptw_fault  <= 1'b1;
                        ptw_rvalid <= 1'b1;
                        state      <= ST_PTW_RESP;
                    end else if (ptw_ok && bus_gnt) begin
                        state <= ST_PTW_WAIT;
                        cnt   <= '0;
                    end else if (core_req && bus_gnt) begin
                        state <= ST_CORE_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PTW_WAIT: begin
                    if (bus_rvalid) begin
                        ptw_rdata  <= bus_rdata;
                        ptw_fault  <= bus_err;
                        ptw_rvalid <= 1'b1;
                        state      <= ST_PTW_RESP;
                    end else if (timeout) begin
                        ptw_rdata  <= '0;
                        ptw_fault  <= 1'b1;
                        ptw_rvalid <= 1'b1;
                        drain_pend <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_PTW_RESP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_PTW_RESP: begin
                    drain_pend <= 1'b0;
                    state <= drain_pend ? ST_DRAIN : ST_IDLE;
                end
                ST_CORE_WAIT: begin
                    if (bus_rvalid) begin
                        state <= ST_IDLE;
                    end else if (timeout) begin
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DRAIN: begin
                    // The abandoned response is swallowed here, never forwarded
                    if (bus_rvalid || timeout) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_dbus_arb.sv
// Randomized bench for ptw_dbus_arb against a transaction-timing model.
// Scenario tasks schedule expected outputs; one negedge process compares.
module tb_ptw_dbus_arb;

    localparam logic [31:0] PTB = 32'h0010_0000;
    localparam logic [31:0] PTE = 32'h001F_FFFF;
    localparam int          TO  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        ptw_req;
    logic [31:0] ptw_addr;
    logic [31:0] ptw_rdata;
    logic        ptw_rvalid;
    logic        ptw_fault;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_we;
    logic [31:0] core_wdata;
    logic [3:0]  core_be;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    ptw_dbus_arb dut (
        .clk(clk), .rst(rst),
        .ptw_req(ptw_req), .ptw_addr(ptw_addr),
        .ptw_rdata(ptw_rdata), .ptw_rvalid(ptw_rvalid),
        .ptw_fault(ptw_fault),
        .core_req(core_req), .core_addr(core_addr),
        .core_we(core_we), .core_wdata(core_wdata),
        .core_be(core_be), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_err(core_err),
        .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    logic        exp_bus_req, exp_bus_we, exp_core_gnt;
    logic [31:0] exp_bus_addr, exp_bus_wdata, exp_core_rdata;
    logic [3:0]  exp_bus_be;
    logic        exp_ptw_rvalid, exp_core_rvalid, exp_core_err;
    logic        exp_core_rdchk;
    logic [31:0] m_rdata;
    logic        m_fault;

    int          n_pulse = 0, n_breq = 0, n_issue = 0, n_cgnt = 0;
    logic [31:0] last_rd, prev_iss, last_iss;
    logic        last_flt;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("bus_req", 32'(bus_req), 32'(exp_bus_req));
            if (exp_bus_req) begin
                cmp("bus_addr", bus_addr, exp_bus_addr);
                cmp("bus_we", 32'(bus_we), 32'(exp_bus_we));
                cmp("bus_be", 32'(bus_be), 32'(exp_bus_be));
                if (exp_bus_we)
                    cmp("bus_wdata", bus_wdata, exp_bus_wdata);
            end
            cmp("core_gnt", 32'(core_gnt), 32'(exp_core_gnt));
            cmp("ptw_rvalid", 32'(ptw_rvalid), 32'(exp_ptw_rvalid));
            cmp("ptw_rdata", ptw_rdata, m_rdata);
            cmp("ptw_fault", 32'(ptw_fault), 32'(m_fault));
            cmp("core_rvalid", 32'(core_rvalid), 32'(exp_core_rvalid));
            if (exp_core_rvalid)
                cmp("core_err", 32'(core_err), 32'(exp_core_err));
            if (exp_core_rdchk)
                cmp("core_rdata", core_rdata, exp_core_rdata);
            if (ptw_rvalid === 1'b1) begin
                n_pulse++;
                last_rd = ptw_rdata;
                last_flt = ptw_fault;
            end
            if (bus_req === 1'b1) n_breq++;
            if (bus_req === 1'b1 && bus_gnt) begin
                n_issue++;
                prev_iss = last_iss;
                last_iss = bus_addr;
            end
            if (core_gnt === 1'b1) n_cgnt++;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        exp_bus_req = 0; exp_bus_we = 0; exp_bus_be = 0;
        exp_bus_addr = 0; exp_bus_wdata = 0; exp_core_gnt = 0;
        exp_ptw_rvalid = 0; exp_core_rvalid = 0; exp_core_err = 0;
        exp_core_rdchk = 0; exp_core_rdata = 0;
    endtask

    task automatic exp_core_on_bus();
        exp_bus_req = 1;
        exp_bus_addr = core_addr;
        exp_bus_we = core_we;
        exp_bus_wdata = core_wdata;
        exp_bus_be = core_be;
    endtask

    task automatic idle_task(input int n);
        for (int i = 0; i < n; i++) begin
            nxt();
            ptw_req = 0; core_req = 0;
            bus_gnt = 1'($urandom);
            bus_rvalid = 1'($urandom);
            bus_rdata = $urandom;
            bus_err = 1'($urandom);
        end
    endtask

    // Abandoned-response window; a probe core request must stay blocked.
    task automatic drain(input int late);
        for (int i = 0; i <= late; i++) begin
            nxt();
            ptw_req = 0; core_req = 1; bus_gnt = 0;
            bus_rvalid = (i == late);
            bus_rdata = $urandom;
            bus_err = 1'($urandom);
        end
        nxt();
        bus_rvalid = 0;
        exp_core_on_bus();
    endtask

    task automatic ptw_txn(input logic [31:0] a, input int g, input int k,
                           input logic [31:0] d, input logic e,
                           input bit hc, input int late);
        bit ok;
        int lim;
        ok = (a[1:0] == 2'b00) && (a >= PTB) && (a <= PTE);
        nxt();
        ptw_req = 1; ptw_addr = a; core_req = hc;
        core_addr = $urandom; core_we = 1'($urandom);
        core_wdata = $urandom; core_be = 4'($urandom);
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom; bus_err = 0;
        if (!ok) begin
            bus_gnt = 1'($urandom);
            nxt();
            bus_gnt = 0;
            exp_ptw_rvalid = 1; m_rdata = 0; m_fault = 1;
            return;
        end
        for (int i = 0; i <= g; i++) begin
            if (i > 0) nxt();
            bus_gnt = (i == g);
            exp_bus_req = 1; exp_bus_addr = a;
            exp_bus_we = 0; exp_bus_be = 4'hF;
        end
        lim = (k > 0) ? k : TO + 1;
        for (int j = 1; j <= lim; j++) begin
            nxt();
            bus_gnt = 0;
            bus_rvalid = (j == k);
            bus_rdata = (j == k) ? d : $urandom;
            bus_err = (j == k) ? e : 1'($urandom);
        end
        nxt();
        bus_rvalid = 0;
        exp_ptw_rvalid = 1;
        m_rdata = (k > 0) ? d : 32'h0;
        m_fault = (k > 0) ? e : 1'b1;
        if (k == 0) drain(late);
    endtask

    task automatic core_txn(input logic [31:0] a, input logic we,
                            input int g, input int k, input int late);
        int lim;
        logic e;
        e = ($urandom_range(0, 7) == 0);
        nxt();
        ptw_req = 0; core_req = 1; core_addr = a; core_we = we;
        core_wdata = $urandom; core_be = 4'($urandom);
        bus_rvalid = 0;
        for (int i = 0; i <= g; i++) begin
            if (i > 0) nxt();
            bus_gnt = (i == g);
            exp_core_on_bus();
            exp_core_gnt = (i == g);
        end
        lim = (k > 0) ? k : TO + 1;
        for (int j = 1; j <= lim; j++) begin
            nxt();
            core_req = 1'($urandom);
            bus_gnt = 1'($urandom);
            bus_rvalid = (j == k);
            bus_rdata = $urandom;
            bus_err = (j == k) ? e : 1'($urandom);
            if (j == k) begin
                exp_core_rvalid = 1; exp_core_err = e;
                exp_core_rdchk = 1; exp_core_rdata = bus_rdata;
            end
            if (k == 0 && j == lim) begin
                exp_core_rvalid = 1; exp_core_err = 1;
            end
        end
        if (k == 0) drain(late);
    endtask

    function automatic logic [31:0] rand_ok();
        return PTB + ($urandom_range(0, 32'h3_FFFF) << 2);
    endfunction

    function automatic logic [31:0] rand_bad();
        case ($urandom_range(0, 2))
            0: return $urandom_range(0, PTB - 1);
            1: return PTE + 1 + $urandom_range(0, 32'h0FFF_FFFF);
            default: return rand_ok() | $urandom_range(1, 3);
        endcase
    endfunction

    initial begin
        int p0, b0, c0, i0;
        rst = 1; ptw_req = 0; ptw_addr = 0; core_req = 0;
        core_addr = 0; core_we = 0; core_wdata = 0; core_be = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
        m_rdata = 0; m_fault = 0;
        nxt();
        chk_on = 1;
        core_req = 1;
        nxt();
        nxt();
        rst = 0; core_req = 0;

        p0 = n_pulse;
        ptw_txn(32'h0010_0404, 0, 2, 32'h0004_00CF, 0, 0, 0);
        idle_task(1);
        cmp("lit_pulse", 32'(n_pulse - p0), 1);
        cmp("lit_rdata", last_rd, 32'h0004_00CF);
        cmp("lit_fault", 32'(last_flt), 0);

        p0 = n_pulse; b0 = n_breq;
        ptw_txn(32'h0000_1000, 0, 1, 0, 0, 0, 0);
        ptw_txn(32'h0010_0002, 0, 1, 0, 0, 0, 0);
        idle_task(1);
        cmp("lit_badpulse", 32'(n_pulse - p0), 2);
        cmp("lit_badfault", 32'(last_flt), 1);
        cmp("lit_nobusreq", 32'(n_breq - b0), 0);

        c0 = n_cgnt;
        ptw_txn(32'h0010_0100, 1, 3, $urandom, 0, 1, 0);
        core_txn(32'h0000_8000, 1, 0, 2, 0);
        idle_task(1);
        cmp("lit_cgnt", 32'(n_cgnt - c0), 1);

        i0 = n_issue;
        ptw_txn(32'h0010_0800, 0, 1, 32'h0020_0001, 0, 0, 0);
        ptw_txn(32'h0010_2000, 2, 3, 32'h0030_00CF, 0, 0, 0);
        idle_task(1);
        cmp("lit_issues", 32'(n_issue - i0), 2);
        cmp("lit_iss1", prev_iss, 32'h0010_0800);
        cmp("lit_iss2", last_iss, 32'h0010_2000);

        p0 = n_pulse;
        ptw_txn(32'h0010_0040, 0, 0, 0, 0, 0, 3);
        ptw_txn(rand_ok(), 1, 2, $urandom, 0, 0, 0);
        idle_task(1);
        cmp("lit_to_pulses", 32'(n_pulse - p0), 2);
        core_txn($urandom, 0, 1, 0, 5);
        ptw_txn(rand_ok(), 0, TO + 1, 32'hCAFE_0001, 0, 0, 0);
        core_txn($urandom, 1, 0, 1, 0);

        ptw_txn(PTB, 0, 1, $urandom, 0, 0, 0);
        ptw_txn(PTE - 3, 0, 1, $urandom, 1, 0, 0);
        ptw_txn(PTE, 0, 1, 0, 0, 0, 0);
        ptw_txn(PTB - 4, 0, 1, 0, 0, 1, 0);
        ptw_txn(PTE + 1, 0, 1, 0, 0, 0, 0);

        nxt();
        ptw_req = 1; ptw_addr = 32'h0010_0010; core_req = 0;
        bus_gnt = 1; bus_rvalid = 0;
        exp_bus_req = 1; exp_bus_addr = ptw_addr; exp_bus_be = 4'hF;
        nxt();
        bus_gnt = 0;
        nxt();
        rst = 1; core_req = 1;
        nxt();
        rst = 0; ptw_req = 0; core_req = 0;
        bus_rvalid = 1; bus_rdata = $urandom;
        m_rdata = 0; m_fault = 0;
        nxt();
        bus_rvalid = 0;

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: ptw_txn(rand_ok(), $urandom_range(0, 3),
                           $urandom_range(1, 6), $urandom,
                           ($urandom_range(0, 7) == 0),
                           1'($urandom), 0);
                1: ptw_txn(rand_bad(), 0, 1, 0, 0, 1'($urandom), 0);
                2: core_txn($urandom, 1'($urandom),
                            $urandom_range(0, 3),
                            $urandom_range(1, 6), 0);
                3: idle_task($urandom_range(1, 3));
                default: begin
                    ptw_txn(rand_ok(), 0, $urandom_range(1, 4),
                            $urandom, 0, 0, 0);
                    ptw_txn(rand_ok(), $urandom_range(0, 2),
                            $urandom_range(1, 4), $urandom, 0, 0, 0);
                end
            endcase
        end
        idle_task(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
